// File: rtl/fetch_pc_select.sv
// Y86-64 fetch PC selection: predicted-PC register, redirect mux and ret-wait FSM.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_pc_select #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_valid,
  output logic [ADDR_W-1:0] F_predPC,
  output logic              ret_pending,
  output logic [31:0]       mispredict_cnt,
  output logic [31:0]       ret_cnt
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] pred_r;
  logic [ADDR_W-1:0] pred_next_s;
  logic [ADDR_W-1:0] pred_target_s;
  logic              mispredict_s;
  logic              ret_done_s;

  assign mispredict_s = (M_icode == I_JXX) && !M_cnd;
  assign ret_done_s   = (W_icode == I_RET);
  assign F_predPC     = pred_r;
  assign ret_pending  = (state_r == RET_WAIT);

  // Fetch address select and prediction target for the instruction at f_pc.
  always_comb begin
    f_pc          = pred_r;
    pred_target_s = f_valP;
    if (mispredict_s) begin
      f_pc = M_valA;
    end else if (ret_done_s) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_r;
    end
    if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
      pred_target_s = f_valC;
    end else begin
      pred_target_s = f_valP;
    end
  end

  // Next-state, next prediction and fetch-valid decode.
  always_comb begin
    state_next_s = state_r;
    pred_next_s  = pred_r;
    f_valid      = 1'b0;
    case (state_r)
      RUN: begin
        f_valid = 1'b1;
        // A redirect always loads the register, even against a stall.
        if (mispredict_s || ret_done_s) begin
          pred_next_s  = pred_target_s;
          state_next_s = (f_icode == I_RET) ? RET_WAIT : RUN;
        end else if (F_stall) begin
          pred_next_s  = pred_r;
          state_next_s = RUN;
        end else if (f_icode == I_RET) begin
          pred_next_s  = f_valP;
          state_next_s = RET_WAIT;
        end else begin
          pred_next_s  = pred_target_s;
          state_next_s = RUN;
        end
      end
      RET_WAIT: begin
        if (mispredict_s || ret_done_s) begin
          f_valid      = 1'b1;
          pred_next_s  = pred_target_s;
          state_next_s = RUN;
        end else begin
          f_valid      = 1'b0;
          pred_next_s  = pred_r;
          state_next_s = RET_WAIT;
        end
      end
      default: begin
        f_valid      = 1'b0;
        pred_next_s  = RESET_PC;
        state_next_s = RUN;
      end
    endcase
    if (!rst_n) begin
      f_valid = 1'b0;
    end else begin
      f_valid = f_valid;
    end
  end

  // Predicted-PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_r  <= RESET_PC;
      state_r <= RUN;
    end else begin
      pred_r  <= pred_next_s;
      state_r <= state_next_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] mispredict_cnt_r;
  logic [31:0] ret_cnt_r;

  // Event counters; ret_cnt only counts returns that release a parked fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_cnt_r <= 32'h0;
      ret_cnt_r        <= 32'h0;
    end else begin
      if (mispredict_s) begin
        mispredict_cnt_r <= mispredict_cnt_r + 32'h1;
      end else begin
        mispredict_cnt_r <= mispredict_cnt_r;
      end
      if (ret_done_s && (state_r == RET_WAIT)) begin
        ret_cnt_r <= ret_cnt_r + 32'h1;
      end else begin
        ret_cnt_r <= ret_cnt_r;
      end
    end
  end

  assign mispredict_cnt = mispredict_cnt_r;
  assign ret_cnt        = ret_cnt_r;
`else
  assign mispredict_cnt = 32'h0;
  assign ret_cnt        = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_select.sv
// Self-checking bench for fetch_pc_select: directed vector table plus random stimulus
// against a behavioural model.
module tb_fetch_pc_select;

  localparam logic [3:0] NOP  = 4'h6;
  localparam logic [3:0] JXX  = 4'h7;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET  = 4'h9;
  localparam logic [3:0] IDL  = 4'h0;
`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, F_stall, M_cnd;
  logic [3:0]  f_icode, M_icode, W_icode;
  logic [63:0] f_valC, f_valP, M_valA, W_valM;
  logic [63:0] f_pc, F_predPC;
  logic        f_valid, ret_pending;
  logic [31:0] mispredict_cnt, ret_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_pc_select dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .f_icode(f_icode),
    .f_valC(f_valC), .f_valP(f_valP), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc),
    .f_valid(f_valid), .F_predPC(F_predPC), .ret_pending(ret_pending),
    .mispredict_cnt(mispredict_cnt), .ret_cnt(ret_cnt)
  );

  typedef struct {
    logic        rst_n, stall;
    logic [3:0]  fi;
    logic [63:0] valc, valp;
    logic [3:0]  mi;
    logic        mcnd;
    logic [63:0] mva;
    logic [3:0]  wi;
    logic [63:0] wvm;
    logic [63:0] epc;
    logic        ev;
    logic [63:0] epred;
    logic        epend;
    logic [31:0] emc, erc;
    logic        ck;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] fi,
                              input logic [63:0] vc, input logic [63:0] vp,
                              input logic [3:0] mi, input logic mc, input logic [63:0] mva,
                              input logic [3:0] wi, input logic [63:0] wvm,
                              input logic [63:0] epc, input logic ev, input logic [63:0] epr,
                              input logic ep, input logic [31:0] emc, input logic [31:0] erc,
                              input logic ck);
    vec_t v;
    v.rst_n = r; v.stall = s; v.fi = fi; v.valc = vc; v.valp = vp;
    v.mi = mi; v.mcnd = mc; v.mva = mva; v.wi = wi; v.wvm = wvm;
    v.epc = epc; v.ev = ev; v.epred = epr; v.epend = ep;
    v.emc = emc; v.erc = erc; v.ck = ck;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] fi,
                       input logic [63:0] vc, input logic [63:0] vp, input logic [3:0] mi,
                       input logic mc, input logic [63:0] mva, input logic [3:0] wi,
                       input logic [63:0] wvm);
    rst_n = r; F_stall = s; f_icode = fi; f_valC = vc; f_valP = vp;
    M_icode = mi; M_cnd = mc; M_valA = mva; W_icode = wi; W_valM = wvm;
  endtask

  // Behavioural reference state
  logic [63:0] m_pred;
  bit          m_parked;
  logic [31:0] m_mc, m_rc;

  vec_t tbl[22];

  initial begin
    drive(1'b0, 1'b0, NOP, 64'h0, 64'h0, IDL, 1'b1, 64'h0, IDL, 64'h0);
    @(posedge clk); #1;

    tbl[0]  = mk(1'b0,1'b0,NOP,64'h0,64'h2,   IDL,1'b1,64'h0,  IDL,64'h0,  64'h0,  1'b0,64'h0,  1'b0,32'd0,32'd0,1'b0);
    tbl[1]  = mk(1'b0,1'b0,NOP,64'h0,64'h2,   IDL,1'b1,64'h0,  IDL,64'h0,  64'h0,  1'b0,64'h0,  1'b0,32'd0,32'd0,1'b1);
    tbl[2]  = mk(1'b1,1'b0,NOP,64'h0,64'h2,   IDL,1'b1,64'h0,  IDL,64'h0,  64'h0,  1'b1,64'h0,  1'b0,32'd0,32'd0,1'b1);
    tbl[3]  = mk(1'b1,1'b0,JXX,64'h10,64'hb,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h2,  1'b1,64'h2,  1'b0,32'd0,32'd0,1'b1);
    tbl[4]  = mk(1'b1,1'b0,JXX,64'h100,64'h19,IDL,1'b1,64'h0,  IDL,64'h0,  64'h10, 1'b1,64'h10, 1'b0,32'd0,32'd0,1'b1);
    tbl[5]  = mk(1'b1,1'b0,NOP,64'h0,64'h10a, JXX,1'b0,64'h19, IDL,64'h0,  64'h19, 1'b1,64'h100,1'b0,32'd0,32'd0,1'b1);
    tbl[6]  = mk(1'b1,1'b0,CALL,64'h30,64'h22,IDL,1'b1,64'h0,  IDL,64'h0,  64'h10a,1'b1,64'h10a,1'b0,32'd1,32'd0,1'b1);
    tbl[7]  = mk(1'b1,1'b0,RET,64'h0,64'h31,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h30, 1'b1,64'h30, 1'b0,32'd1,32'd0,1'b1);
    tbl[8]  = mk(1'b1,1'b1,NOP,64'h0,64'h77,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h31, 1'b0,64'h31, 1'b1,32'd1,32'd0,1'b1);
    tbl[9]  = mk(1'b1,1'b0,NOP,64'h0,64'h77,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h31, 1'b0,64'h31, 1'b1,32'd1,32'd0,1'b1);
    tbl[10] = mk(1'b1,1'b1,NOP,64'h0,64'h77,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h31, 1'b0,64'h31, 1'b1,32'd1,32'd0,1'b1);
    tbl[11] = mk(1'b1,1'b0,NOP,64'h0,64'h59,  IDL,1'b1,64'h0,  RET,64'h58, 64'h58, 1'b1,64'h31, 1'b1,32'd1,32'd0,1'b1);
    tbl[12] = mk(1'b1,1'b0,RET,64'h0,64'h5a,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h59, 1'b1,64'h59, 1'b0,32'd1,32'd1,1'b1);
    tbl[13] = mk(1'b1,1'b0,NOP,64'h0,64'h42,  JXX,1'b0,64'h40, IDL,64'h0,  64'h40, 1'b1,64'h5a, 1'b1,32'd1,32'd1,1'b1);
    tbl[14] = mk(1'b1,1'b1,NOP,64'h0,64'h99,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h42, 1'b1,64'h42, 1'b0,32'd2,32'd1,1'b1);
    tbl[15] = mk(1'b1,1'b1,NOP,64'h0,64'h99,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h42, 1'b1,64'h42, 1'b0,32'd2,32'd1,1'b1);
    tbl[16] = mk(1'b1,1'b1,NOP,64'h0,64'h81,  IDL,1'b1,64'h0,  RET,64'h80, 64'h80, 1'b1,64'h42, 1'b0,32'd2,32'd1,1'b1);
    tbl[17] = mk(1'b1,1'b0,NOP,64'h0,64'h90,  JXX,1'b0,64'h11, RET,64'h22, 64'h11, 1'b1,64'h81, 1'b0,32'd2,32'd1,1'b1);
    tbl[18] = mk(1'b1,1'b0,RET,64'h0,64'h91,  IDL,1'b1,64'h0,  IDL,64'h0,  64'h90, 1'b1,64'h90, 1'b0,32'd3,32'd1,1'b1);
    tbl[19] = mk(1'b0,1'b0,NOP,64'h0,64'h4,   IDL,1'b1,64'h0,  IDL,64'h0,  64'h91, 1'b0,64'h91, 1'b1,32'd3,32'd1,1'b1);
    tbl[20] = mk(1'b1,1'b0,NOP,64'h0,64'h4,   IDL,1'b1,64'h0,  IDL,64'h0,  64'h0,  1'b1,64'h0,  1'b0,32'd0,32'd0,1'b1);
    tbl[21] = mk(1'b1,1'b0,NOP,64'h0,64'h8,   JXX,1'b1,64'h55, IDL,64'h0,  64'h4,  1'b1,64'h4,  1'b0,32'd0,32'd0,1'b1);

    // Directed table: each row is checked before the edge it is clocked into.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].fi, tbl[i].valc, tbl[i].valp,
            tbl[i].mi, tbl[i].mcnd, tbl[i].mva, tbl[i].wi, tbl[i].wvm);
      @(negedge clk);
      if (tbl[i].ck) begin
        chk($sformatf("vec%0d f_pc", i), f_pc, tbl[i].epc);
        chk($sformatf("vec%0d f_valid", i), 64'(f_valid), 64'(tbl[i].ev));
        chk($sformatf("vec%0d F_predPC", i), F_predPC, tbl[i].epred);
        chk($sformatf("vec%0d ret_pending", i), 64'(ret_pending), 64'(tbl[i].epend));
        chk($sformatf("vec%0d mispredict_cnt", i), 64'(mispredict_cnt),
            CNT_EN ? 64'(tbl[i].emc) : 64'h0);
        chk($sformatf("vec%0d ret_cnt", i), 64'(ret_cnt),
            CNT_EN ? 64'(tbl[i].erc) : 64'h0);
      end
      @(posedge clk); #1;
    end

    // Random phase against the reference model, starting from a fresh reset.
    drive(1'b0, 1'b0, NOP, 64'h0, 64'h0, IDL, 1'b1, 64'h0, IDL, 64'h0);
    @(posedge clk); #1;
    m_pred = 64'h0; m_parked = 1'b0; m_mc = 32'd0; m_rc = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  fi, mi, wi;
      logic [63:0] exp_pc, target;
      bit          mis, rd, r;
      r  = ($urandom_range(0, 99) != 0);
      fi = 4'($urandom_range(0, 11));
      mi = ($urandom_range(0, 3) == 0) ? JXX : 4'($urandom_range(0, 11));
      wi = ($urandom_range(0, 5) == 0) ? RET : 4'($urandom_range(0, 8));
      drive(r, 1'($urandom_range(0, 3) == 0), fi, {$urandom, $urandom}, {$urandom, $urandom},
            mi, 1'($urandom_range(0, 1)), {$urandom, $urandom}, wi, {$urandom, $urandom});
      mis    = (M_icode == JXX) && !M_cnd;
      rd     = (W_icode == RET);
      exp_pc = mis ? M_valA : (rd ? W_valM : m_pred);
      target = (f_icode == JXX || f_icode == CALL) ? f_valC : f_valP;
      @(negedge clk);
      chk("rnd f_pc", f_pc, exp_pc);
      chk("rnd f_valid", 64'(f_valid), 64'(r && (!m_parked || mis || rd)));
      chk("rnd F_predPC", F_predPC, m_pred);
      chk("rnd ret_pending", 64'(ret_pending), 64'(m_parked));
      chk("rnd mispredict_cnt", 64'(mispredict_cnt), CNT_EN ? 64'(m_mc) : 64'h0);
      chk("rnd ret_cnt", 64'(ret_cnt), CNT_EN ? 64'(m_rc) : 64'h0);
      @(posedge clk); #1;
      if (!r) begin
        m_pred = 64'h0; m_parked = 1'b0; m_mc = 32'd0; m_rc = 32'd0;
      end else begin
        if (mis) m_mc = m_mc + 32'd1;
        if (rd && m_parked) m_rc = m_rc + 32'd1;
        if (mis || rd) begin
          m_pred   = target;
          m_parked = !m_parked && (f_icode == RET);
        end else if (!m_parked && !F_stall) begin
          m_pred   = target;
          m_parked = (f_icode == RET);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
